// File: rtl/bank_streamer.sv
// bank_streamer
//   Snapshots a DEPTH x WIDTH register bank on request and streams the first
//   count_i words out over a valid/ready handshake, so the bank can keep taking
//   pushes while the stream drains.
//
// Ports
//   clk_i    in   single clock, rising edge
//   rst_i    in   asynchronous active-high reset
//   start_i  in   snapshot+stream request, sampled only in IDLE
//   count_i  in   words to stream (0..DEPTH, larger values clamp to DEPTH)
//   bank_i   in   bank contents, word k = bank_i[k*WIDTH +: WIDTH]
//   ready_i  in   downstream ready
//   data_o   out  current word
//   valid_o  out  data_o valid
//   last_o   out  current word is the final one of the burst
//   busy_o   out  high in STREAM and DONE
//   done_o   out  one-cycle pulse at the end of a burst
module bank_streamer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [CW-1:0]          count_i,
    input  logic [DEPTH*WIDTH-1:0] bank_i,
    input  logic                   ready_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    // Width needed to address one of DEPTH snapshot words.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_clamped;
    logic [CW-1:0]    idx_next;
    logic [WIDTH-1:0] snap [DEPTH];

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             last_r;
    logic             busy_r;
    logic             done_r;

    always_comb begin
        cnt_clamped = (count_i > CW'(DEPTH)) ? CW'(DEPTH) : count_i;
        idx_next    = idx + CW'(1);
    end

    // Outputs are registered: the word, valid and last for the next cycle are
    // loaded in the same edge that moves idx, so they never glitch while
    // stalled and all clear asynchronously on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                snap[k] <= '0;
            end
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (start_i) begin
                        if (cnt_clamped != '0) begin
                            for (int unsigned k = 0; k < DEPTH; k++) begin
                                snap[k] <= bank_i[k*WIDTH +: WIDTH];
                            end
                            cnt     <= cnt_clamped;
                            idx     <= '0;
                            data_r  <= bank_i[0 +: WIDTH];
                            valid_r <= 1'b1;
                            last_r  <= (cnt_clamped == CW'(1));
                            busy_r  <= 1'b1;
                            state   <= STREAM;
                        end else begin
                            // Empty burst: go straight to the done pulse.
                            busy_r <= 1'b1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                STREAM: begin
                    // valid_r is always high here, so ready_i alone marks a handshake.
                    if (ready_i) begin
                        if (last_r) begin
                            data_r  <= '0;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            idx    <= idx_next;
                            data_r <= snap[idx_next[IW-1:0]];
                            last_r <= (idx_next == cnt - CW'(1));
                        end
                    end
                end

                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;
    assign last_o  = last_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;

endmodule

// File: tb/tb_bank_streamer.sv
// tb_bank_streamer
//   Self-checking bench for bank_streamer. Bursts are driven with random bank
//   contents and random backpressure; a reference model takes the bank words
//   present at the start edge and expects the first min(count, DEPTH) of them,
//   in order, with last on the final word and one done pulse right after.
module tb_bank_streamer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [CW-1:0]          count;
    logic [DEPTH*WIDTH-1:0] bank;
    logic                   ready;
    logic [WIDTH-1:0]       data;
    logic                   valid;
    logic                   last;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    bank_streamer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .count_i (count),
        .bank_i  (bank),
        .ready_i (ready),
        .data_o  (data),
        .valid_o (valid),
        .last_o  (last),
        .busy_o  (busy),
        .done_o  (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] words [DEPTH];
    bit               ready_pat [$];

    // Observations of the most recent burst.
    logic [WIDTH-1:0] got_data [$];
    bit               got_last [$];
    logic [WIDTH-1:0] exp_q [$];
    int exp_n, stall_changes, done_count, done_cycle, last_hs_cycle, first_valid_cycle;
    int timed_out, busy_gap, end_busy, done_start_effect;
    int word_errs, last_errs, first_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bank();
        for (int k = 0; k < DEPTH; k++) bank[k*WIDTH +: WIDTH] = words[k];
    endtask

    task automatic randomize_words();
        for (int k = 0; k < DEPTH; k++) words[k] = $urandom;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        count = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Drives one burst from IDLE and records what came out. Expected words are
    // the bank contents at the start edge; afterwards the bank is scrambled.
    task automatic run_burst(input int cnt, input int ready_pct, input bit ff_after,
                             input int mid_start_at, input bit start_in_done);
        logic [WIDTH-1:0] pw;
        bit pl, pstall, seen_done, hs;
        int c;
        got_data = {};
        got_last = {};
        exp_q    = {};
        stall_changes = 0; done_count = 0; done_cycle = -1; last_hs_cycle = -1;
        first_valid_cycle = -1; timed_out = 0; busy_gap = 0; end_busy = -1;
        done_start_effect = -1;
        exp_n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int k = 0; k < exp_n; k++) exp_q.push_back(words[k]);

        drive_bank();
        count = CW'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;

        c = 0; seen_done = 0; pstall = 0; pw = '0; pl = 0;
        while (1) begin
            if (c >= 400) begin
                timed_out = 1;
                break;
            end
            if (valid) begin
                if (first_valid_cycle < 0) first_valid_cycle = c;
                if (pstall && (data !== pw || last !== pl)) stall_changes++;
            end
            if ((valid || done) && !busy) busy_gap++;
            if (seen_done && !done) begin
                end_busy = int'(busy);
                done_start_effect = int'(valid | busy);
                break;
            end
            if (done) begin
                done_count++;
                done_cycle = c;
                seen_done  = 1;
            end
            if (c < ready_pat.size()) ready = ready_pat[c];
            else ready = (int'($urandom_range(99)) < ready_pct);
            hs = valid && ready;
            if (hs) begin
                got_data.push_back(data);
                got_last.push_back(last);
                last_hs_cycle = c;
            end
            pstall = valid && !ready;
            pw = data;
            pl = last;
            start = 1'b0;
            if (c == mid_start_at) begin
                start = 1'b1;
                count = CW'(2);
            end
            if (done && start_in_done) begin
                start = 1'b1;
                count = CW'(5);
            end
            for (int k = 0; k < DEPTH; k++) words[k] = ff_after ? '1 : $urandom;
            drive_bank();
            tick();
            c++;
        end
        start = 1'b0;

        word_errs = 0; last_errs = 0; first_bad = -1;
        for (int i = 0; i < got_data.size() && i < exp_n; i++) begin
            if (got_data[i] !== exp_q[i]) begin
                word_errs++;
                if (first_bad < 0) first_bad = i;
            end
        end
        for (int i = 0; i < got_last.size(); i++) begin
            if (got_last[i] != (i == exp_n - 1)) last_errs++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0; count = '0; bank = '0;
        tick();
        n_tests++;
        if ({valid, last, busy, done, data} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs %0h, required 0", {valid, last, busy, done, data});
        end
        rst = 1'b0;
        tick();
        randomize_words();
        drive_bank();
        ready = 1'b1;
        count = CW'(32);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_tests++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_stream: valid=%0b busy=%0b, required 1 1", valid, busy);
        end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if ({valid, busy, done, last} !== 4'b0 || data !== '0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%0b busy=%0b done=%0b last=%0b data=%0h, required all 0",
                     valid, busy, done, last, data);
        end
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if ({valid, busy, done} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: valid=%0b busy=%0b done=%0b, required 0 0 0", valid, busy, done);
        end
    endtask

    task automatic test_full_burst();
        apply_reset();
        for (int k = 0; k < DEPTH; k++) words[k] = 32'hA000_0000 + WIDTH'(k);
        ready_pat = {};
        run_burst(32, 100, 1'b0, -1, 1'b0);
        n_tests++;
        if (timed_out != 0 || got_data.size() != 32) begin
            n_fail++;
            $display("FAIL full_count: got %0d words (timeout=%0d), required 32", got_data.size(), timed_out);
        end
        n_tests++;
        if (word_errs != 0) begin
            n_fail++;
            $display("FAIL full_words: %0d bad words, first at %0d, required 0", word_errs, first_bad);
        end
        n_tests++;
        if (last_errs != 0) begin
            n_fail++;
            $display("FAIL full_last: %0d misplaced last flags, required 0", last_errs);
        end
        n_tests++;
        if (first_valid_cycle != 0 || last_hs_cycle != 31) begin
            n_fail++;
            $display("FAIL full_timing: first valid %0d last handshake %0d, required 0 31",
                     first_valid_cycle, last_hs_cycle);
        end
        n_tests++;
        if (done_count != 1 || done_cycle != 32) begin
            n_fail++;
            $display("FAIL full_done: %0d pulses at cycle %0d, required 1 at 32", done_count, done_cycle);
        end
        n_tests++;
        if (busy_gap != 0 || end_busy != 0) begin
            n_fail++;
            $display("FAIL full_busy: gaps %0d final busy %0d, required 0 0", busy_gap, end_busy);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        randomize_words();
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_burst(4, 100, 1'b0, -1, 1'b0);
        ready_pat = {};
        n_tests++;
        if (got_data.size() != 4 || word_errs != 0) begin
            n_fail++;
            $display("FAIL bp_words: got %0d words, %0d bad, required 4 and 0", got_data.size(), word_errs);
        end
        n_tests++;
        if (stall_changes != 0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d changes while stalled, required 0", stall_changes);
        end
        n_tests++;
        if (last_errs != 0 || last_hs_cycle != 6 || done_cycle != 7) begin
            n_fail++;
            $display("FAIL bp_timing: last errs %0d, last handshake %0d, done %0d, required 0 6 7",
                     last_errs, last_hs_cycle, done_cycle);
        end
    endtask

    task automatic test_snapshot();
        apply_reset();
        randomize_words();
        run_burst(8, 50, 1'b1, -1, 1'b0);
        n_tests++;
        if (got_data.size() != 8 || word_errs != 0) begin
            n_fail++;
            $display("FAIL snapshot: got %0d words, %0d bad (first %0d), required 8 and 0",
                     got_data.size(), word_errs, first_bad);
        end
    endtask

    task automatic test_edge_counts();
        apply_reset();
        randomize_words();
        run_burst(0, 70, 1'b0, -1, 1'b0);
        n_tests++;
        if (first_valid_cycle != -1 || got_data.size() != 0 || done_count != 1 || done_cycle != 0) begin
            n_fail++;
            $display("FAIL count0: valid at %0d, %0d words, %0d done at %0d, required -1 0 1 0",
                     first_valid_cycle, got_data.size(), done_count, done_cycle);
        end
        randomize_words();
        run_burst(1, 70, 1'b0, -1, 1'b0);
        n_tests++;
        if (got_data.size() != 1 || word_errs != 0 || last_errs != 0 || done_cycle != last_hs_cycle + 1) begin
            n_fail++;
            $display("FAIL count1: %0d words, %0d bad, %0d last errs, done %0d vs handshake %0d, required 1 0 0 hs+1",
                     got_data.size(), word_errs, last_errs, done_cycle, last_hs_cycle);
        end
        randomize_words();
        run_burst(40, 70, 1'b0, -1, 1'b0);
        n_tests++;
        if (got_data.size() != 32 || word_errs != 0 || last_errs != 0) begin
            n_fail++;
            $display("FAIL count40: %0d words, %0d bad, %0d last errs, required 32 0 0",
                     got_data.size(), word_errs, last_errs);
        end
    endtask

    task automatic test_start_busy();
        apply_reset();
        randomize_words();
        run_burst(10, 60, 1'b0, 3, 1'b0);
        n_tests++;
        if (got_data.size() != 10 || word_errs != 0 || last_errs != 0 || done_count != 1) begin
            n_fail++;
            $display("FAIL start_busy: %0d words, %0d bad, %0d last errs, %0d done, required 10 0 0 1",
                     got_data.size(), word_errs, last_errs, done_count);
        end
    endtask

    task automatic test_back_to_back();
        int rc;
        apply_reset();
        ready = 1'b1;
        randomize_words();
        run_burst(5, 100, 1'b0, -1, 1'b1);
        n_tests++;
        if (done_start_effect != 0 || got_data.size() != 5 || word_errs != 0) begin
            n_fail++;
            $display("FAIL start_in_done: effect %0d, %0d words, %0d bad, required 0 5 0",
                     done_start_effect, got_data.size(), word_errs);
        end
        randomize_words();
        run_burst(3, 100, 1'b0, -1, 1'b0);
        n_tests++;
        if (first_valid_cycle != 0 || got_data.size() != 3 || word_errs != 0) begin
            n_fail++;
            $display("FAIL b2b_accept: first valid %0d, %0d words, %0d bad, required 0 3 0",
                     first_valid_cycle, got_data.size(), word_errs);
        end
        for (int i = 0; i < 8; i++) begin
            randomize_words();
            rc = int'($urandom_range(40));
            run_burst(rc, int'($urandom_range(100, 30)), 1'b0, -1, 1'b0);
            n_tests++;
            if (timed_out != 0 || got_data.size() != exp_n || word_errs != 0 ||
                last_errs != 0 || done_count != 1) begin
                n_fail++;
                $display("FAIL random_burst%0d: count %0d got %0d words, %0d bad, %0d last errs, %0d done, timeout %0d",
                         i, rc, got_data.size(), word_errs, last_errs, done_count, timed_out);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_burst();
        test_backpressure();
        test_snapshot();
        test_edge_counts();
        test_start_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
